// File: rtl/weight_writer.sv
// rtl/weight_writer.sv - sequences host weight words into row-major Ising core matrix writes
// Optional WEIGHT_MIRROR_EN: host sends the upper triangle only; off-diagonal words are mirrored.
module weight_writer #(
    parameter int          N           = 3,
    parameter int          NUM_WEIGHTS = 5,
    parameter logic [31:0] ADDR_BASE   = 32'h0,
    parameter int          HOLD_CYCLES = 4
) (
    input  logic        clk,
    input  logic        axi_rst,
    input  logic        start,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [31:0] s_data,
    output logic        wready,
    output logic [31:0] wr_addr,
    output logic [31:0] wdata,
    output logic        ising_rstn,
    output logic        busy,
    output logic        done
);

    localparam int              CW    = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0]   LAST  = CW'(N - 1);
    localparam logic [31:0]     WMASK = (NUM_WEIGHTS >= 32) ? 32'hFFFF_FFFF
                                                            : ((32'd1 << NUM_WEIGHTS) - 32'd1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] LOAD   = 2'd1;
    localparam logic [1:0] HOLD   = 2'd3;
`ifdef WEIGHT_MIRROR_EN
    localparam logic [1:0] MIRROR = 2'd2;
`endif

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] row_q, row_d;
    logic [CW-1:0] col_q, col_d;
    logic [7:0]    hold_q, hold_d;
    logic          wready_q, wready_d;
    logic [31:0]   wr_addr_q, wr_addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          ising_rstn_q, ising_rstn_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
`ifdef WEIGHT_MIRROR_EN
    logic [31:0]   mir_addr_q, mir_addr_d;
`endif

    logic accept;

    function automatic logic [31:0] addr_of(input logic [CW-1:0] r, input logic [CW-1:0] c);
        return ADDR_BASE + (((32'(r) * 32'(N)) + 32'(c)) << 2);
    endfunction

    assign s_ready = (state_q == LOAD);
    assign accept  = s_valid && s_ready;

    always_comb begin
        state_d      = state_q;
        row_d        = row_q;
        col_d        = col_q;
        hold_d       = hold_q;
        wready_d     = 1'b0;
        wr_addr_d    = wr_addr_q;
        wdata_d      = wdata_q;
        ising_rstn_d = ising_rstn_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
`ifdef WEIGHT_MIRROR_EN
        mir_addr_d   = mir_addr_q;
`endif
        case (state_q)
            IDLE: begin
                // A start coinciding with the done pulse is dropped; the host re-issues it.
                if (start && !done_q) begin
                    state_d      = LOAD;
                    row_d        = '0;
                    col_d        = '0;
                    ising_rstn_d = 1'b0;
                    busy_d       = 1'b1;
                end
            end
            LOAD: begin
                if (accept) begin
                    wready_d  = 1'b1;
                    wr_addr_d = addr_of(row_q, col_q);
                    wdata_d   = s_data & WMASK;
                    if (row_q == LAST && col_q == LAST) begin
                        state_d = HOLD;
                        hold_d  = 8'(HOLD_CYCLES);
                        row_d   = '0;
                        col_d   = '0;
                    end else if (col_q == LAST) begin
                        row_d = row_q + CW'(1);
`ifdef WEIGHT_MIRROR_EN
                        col_d = row_q + CW'(1);
`else
                        col_d = '0;
`endif
                    end else begin
                        col_d = col_q + CW'(1);
                    end
`ifdef WEIGHT_MIRROR_EN
                    if (row_q != col_q) begin
                        state_d    = MIRROR;
                        mir_addr_d = addr_of(col_q, row_q);
                    end
`endif
                end
            end
`ifdef WEIGHT_MIRROR_EN
            MIRROR: begin
                wready_d  = 1'b1;
                wr_addr_d = mir_addr_q;
                state_d   = LOAD;
            end
`endif
            HOLD: begin
                if (hold_q <= 8'd1) begin
                    state_d      = IDLE;
                    ising_rstn_d = 1'b1;
                    done_d       = 1'b1;
                    busy_d       = 1'b0;
                end else begin
                    hold_d = hold_q - 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge axi_rst) begin
        if (axi_rst) begin
            state_q      <= IDLE;
            row_q        <= '0;
            col_q        <= '0;
            hold_q       <= '0;
            wready_q     <= 1'b0;
            wr_addr_q    <= '0;
            wdata_q      <= '0;
            ising_rstn_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
`ifdef WEIGHT_MIRROR_EN
            mir_addr_q   <= '0;
`endif
        end else begin
            state_q      <= state_d;
            row_q        <= row_d;
            col_q        <= col_d;
            hold_q       <= hold_d;
            wready_q     <= wready_d;
            wr_addr_q    <= wr_addr_d;
            wdata_q      <= wdata_d;
            ising_rstn_q <= ising_rstn_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
`ifdef WEIGHT_MIRROR_EN
            mir_addr_q   <= mir_addr_d;
`endif
        end
    end

    assign wready     = wready_q;
    assign wr_addr    = wr_addr_q;
    assign wdata      = wdata_q;
    assign ising_rstn = ising_rstn_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_weight_writer.sv
// tb/tb_weight_writer.sv - scoreboard bench for weight_writer (either WEIGHT_MIRROR_EN build)
module tb_weight_writer;

    localparam int N    = 3;
    localparam int HOLD = 4;
`ifdef WEIGHT_MIRROR_EN
    localparam int WORDS = N * (N + 1) / 2;
`else
    localparam int WORDS = N * N;
`endif

    logic        clk = 1'b0;
    logic        axi_rst;
    logic        start;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] s_data;
    logic        wready;
    logic [31:0] wr_addr;
    logic [31:0] wdata;
    logic        ising_rstn;
    logic        busy;
    logic        done;

    weight_writer #(.N(N), .NUM_WEIGHTS(5), .ADDR_BASE(32'h0), .HOLD_CYCLES(HOLD)) dut (
        .clk(clk), .axi_rst(axi_rst), .start(start), .s_valid(s_valid), .s_ready(s_ready),
        .s_data(s_data), .wready(wready), .wr_addr(wr_addr), .wdata(wdata),
        .ising_rstn(ising_rstn), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          last_beat_cyc = 0;
    int          first_beat_cyc = -1;
    int          done_cnt = 0;
    logic        prev_rstn = 1'b0;
    logic [63:0] sb[$];
    int          m_row, m_col;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] beat(input int r, input int c, input logic [31:0] d);
        logic [31:0] a;
        a = 32'((r * N + c) * 4);
        return {a, d & 32'h0000_001F};
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!axi_rst) begin
            if (wready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_beat", wr_addr, 32'hFFFF_FFFF);
                end else begin
                    logic [63:0] e;
                    e = sb.pop_front();
                    chk("wr_addr", wr_addr, e[63:32]);
                    chk("wdata", wdata, e[31:0]);
                end
                last_beat_cyc = cyc;
                if (first_beat_cyc < 0) first_beat_cyc = cyc;
            end
            if (done) begin
                done_cnt++;
                chk("rstn_at_done", 32'(ising_rstn), 32'd1);
                chk("busy_at_done", 32'(busy), 32'd0);
                chk("hold_gap", 32'(cyc - last_beat_cyc), 32'(HOLD));
            end
            if (ising_rstn && !prev_rstn) chk("rstn_rise_with_done", 32'(done), 32'd1);
        end
        prev_rstn = ising_rstn;
    end

    task automatic send_word(input logic [31:0] d);
        int n;
        n = 0;
        s_valid = 1'b1;
        s_data  = d;
        forever begin
            @(negedge clk);
            if (s_ready) begin
                sb.push_back(beat(m_row, m_col, d));
`ifdef WEIGHT_MIRROR_EN
                if (m_row != m_col) sb.push_back(beat(m_col, m_row, d));
                if (m_col == N - 1) begin m_row++; m_col = m_row; end else m_col++;
`else
                if (m_col == N - 1) begin m_row++; m_col = 0; end else m_col++;
`endif
                @(posedge clk); #1;
                s_valid = 1'b0;
                return;
            end
            n++;
            if (n > 50) begin
                chk("s_ready_timeout", 32'd0, 32'd1);
                s_valid = 1'b0;
                return;
            end
        end
    endtask

    task automatic pulse_start(input bit reset_model);
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        if (reset_model) begin m_row = 0; m_col = 0; end
    endtask

    task automatic wait_done(input int base);
        int n;
        n = 0;
        while (done_cnt == base && n < 60) begin
            @(negedge clk); #1;
            n++;
        end
        chk("done_seen", 32'(done_cnt - base), 32'd1);
        repeat (6) @(negedge clk);
        chk("done_once", 32'(done_cnt - base), 32'd1);
        chk("sb_empty", 32'(sb.size()), 32'd0);
    endtask

    task automatic idle(input int k);
        repeat (k) begin @(posedge clk); #1; end
    endtask

    initial begin
        int base;
        axi_rst = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = '0;
        m_row = 0; m_col = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_s_ready", 32'(s_ready), 32'd0);
        chk("rst_wready", 32'(wready), 32'd0);
        chk("rst_wr_addr", wr_addr, 32'd0);
        chk("rst_wdata", wdata, 32'd0);
        chk("rst_rstn", 32'(ising_rstn), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        axi_rst = 1'b0;

        // back-to-back stream 1..WORDS
        base = done_cnt;
        pulse_start(1'b1);
        chk("busy_after_start", 32'(busy), 32'd1);
        chk("s_ready_in_load", 32'(s_ready), 32'd1);
        first_beat_cyc = -1;
        for (int i = 1; i <= WORDS; i++) send_word(32'(i));
        wait_done(base);
        chk("beats_contiguous", 32'(last_beat_cyc - first_beat_cyc), 32'(N * N - 1));
        chk("rstn_high_after_load", 32'(ising_rstn), 32'd1);

        // mask of a full-ones word, then random data
        base = done_cnt;
        pulse_start(1'b1);
        chk("rstn_low_in_load", 32'(ising_rstn), 32'd0);
        send_word(32'hFFFF_FFFF);
        for (int i = 1; i < WORDS; i++) send_word($urandom);
        wait_done(base);

        // gapped valid: 1,0,0,1,0,1,0,0,...
        base = done_cnt;
        pulse_start(1'b1);
        for (int i = 0; i < WORDS; i++) begin
            send_word(32'(100 + i));
            idle((i % 2 == 0) ? 2 : 1);
        end
        wait_done(base);

        // start re-issued mid-load is ignored
        base = done_cnt;
        pulse_start(1'b1);
        for (int i = 0; i < 4; i++) send_word(32'(20 + i));
        pulse_start(1'b0);
        chk("busy_after_restart", 32'(busy), 32'd1);
        for (int i = 4; i < WORDS; i++) send_word(32'(20 + i));
        wait_done(base);

        // asynchronous reset mid-load, then a clean reload
        pulse_start(1'b1);
        for (int i = 0; i < 5; i++) send_word(32'(40 + i));
        axi_rst = 1'b1;
        sb.delete();
        #1;
        chk("arst_wready", 32'(wready), 32'd0);
        chk("arst_s_ready", 32'(s_ready), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_rstn", 32'(ising_rstn), 32'd0);
        chk("arst_wr_addr", wr_addr, 32'd0);
        chk("arst_wdata", wdata, 32'd0);
        idle(2);
        axi_rst = 1'b0;
        base = done_cnt;
        pulse_start(1'b1);
        for (int i = 0; i < WORDS; i++) send_word(32'(60 + i));
        wait_done(base);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=%0d expected=finish", cyc);
        $fatal(1, "timeout");
    end

endmodule
